data_sram_like_slave: RTL and testbench

//   Responder end of the CPU data-memory port: accepts load/store requests issued by EXE stage
//   and returns read data that MEM stage consumes as data_sram_rdata. Implements SRAM-like
//   req/addr_ok/data_ok handshake with fixed latency and multiple outstanding transactions.

---
 rtl/data_sram_like_slave_pkg.sv | 32 +++
 rtl/data_sram_like_slave_resp_fifo.sv | 65 ++++++
 rtl/data_sram_like_slave.sv | 71 +++++++
 tb/tb_data_sram_like_slave.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_like_slave_pkg.sv
// Shared encodings, response entry layout and store-lane merge helper
// for the data-side SRAM-like responder.
package data_sram_like_slave_pkg;

   // data_sram_size encodings (informational only, wstrb decides the lanes)
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam int DATA_W  = 32;
   localparam int STRB_W  = DATA_W / 8;
   localparam int TIMER_W = 3;   // holds RD_LAT-1 for RD_LAT up to 8

   // one outstanding transaction waiting for its data_ok slot
   typedef struct packed {
      logic               is_wr;
      logic [DATA_W-1:0]  rdata;
      logic [TIMER_W-1:0] timer;
   } resp_t;

   // replace only the byte lanes whose strobe is set
   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < STRB_W; i++)
         if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
      return res;
   endfunction

endpackage

// File: rtl/data_sram_like_slave_resp_fifo.sv
// In-order response queue: each entry counts down from RD_LAT-1 and the head
// is presented (and popped) once its timer has reached zero.
module data_sram_like_slave_resp_fifo
   import data_sram_like_slave_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int RD_LAT = 2,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              push_is_wr,
   input  logic [DATA_W-1:0] push_rdata,
   output logic              head_due,
   output logic              head_is_wr,
   output logic [DATA_W-1:0] head_rdata,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(RD_LAT - 1);

   resp_t            ent_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   resp_t            head;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Later entries were pushed later, so the head always reaches zero first;
   // popping whenever the head is due keeps responses strictly in order.
   assign head       = ent_q[rd_ptr];
   assign head_due   = (count != '0) && (head.timer == '0);
   assign head_is_wr = head.is_wr;
   assign head_rdata = head.rdata;
   assign pop        = head_due;

   // pointers, occupancy and per-entry countdown timers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == PTR_W'(i)))
               ent_q[i] <= '{is_wr: push_is_wr, rdata: push_rdata, timer: TIMER_INIT};
            else if (ent_q[i].timer != '0)
               ent_q[i].timer <= ent_q[i].timer - 1'b1;
         end
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/data_sram_like_slave.sv
// Data-side SRAM-like responder: word memory, request acceptance and
// fixed-latency in-order responses with several transactions in flight.
module data_sram_like_slave
   import data_sram_like_slave_pkg::*;
#(
   parameter int IDX_W     = 10,
   parameter int RD_LAT    = 2,
   parameter int MAX_OUTST = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   input  logic        stall_inj,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   logic [DATA_W-1:0] mem_q [2**IDX_W];
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic [DATA_W-1:0] rd_word;
   logic              head_due, head_is_wr;
   logic [DATA_W-1:0] head_rdata;
   logic [CNT_W-1:0]  count;
   logic              unused_bits;

   // size is informational, upper address bits alias, low bits are the CPU's concern
   assign unused_bits = ^{data_sram_size, data_sram_addr[31:IDX_W+2], data_sram_addr[1:0]};

   assign idx    = data_sram_addr[IDX_W+1:2];
   // a retire in this cycle does not free a slot until the next cycle
   assign data_sram_addr_ok = reset && !stall_inj && (count < CNT_W'(MAX_OUTST));
   assign accept = data_sram_req && data_sram_addr_ok;

   // earlier stores have already landed, so this read honours in-order RAW
   assign rd_word = mem_q[idx];

   // memory contents survive reset; only accepted stores touch them
   always_ff @(posedge clk) begin
      if (accept && data_sram_wr)
         mem_q[idx] <= merge_lanes(mem_q[idx], data_sram_wdata, data_sram_wstrb);
   end

   data_sram_like_slave_resp_fifo #(
      .DEPTH  (MAX_OUTST),
      .RD_LAT (RD_LAT),
      .CNT_W  (CNT_W)
   ) u_resp_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (accept),
      .push_is_wr (data_sram_wr),
      .push_rdata (data_sram_wr ? '0 : rd_word),
      .head_due   (head_due),
      .head_is_wr (head_is_wr),
      .head_rdata (head_rdata),
      .count      (count)
   );

   assign data_sram_data_ok = head_due;
   assign data_sram_rdata   = (head_due && !head_is_wr) ? head_rdata : '0;

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Scoreboarded bench: three responder instances with different latency/depth,
// stimulus pushes expected {data, cycle} entries, a negedge monitor pops them.
module tb_data_sram_like_slave;

   logic        clk, reset;
   logic [2:0]  req;
   logic        wr, stall;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata;
   logic [2:0]  addr_ok, data_ok;
   logic [31:0] rdata [3];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int          dut;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   data_sram_like_slave #(.IDX_W(10), .RD_LAT(2), .MAX_OUTST(4)) u_a (
      .clk(clk), .reset(reset), .data_sram_req(req[0]), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .stall_inj(stall), .data_sram_addr_ok(addr_ok[0]),
      .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0]));

   data_sram_like_slave #(.IDX_W(10), .RD_LAT(4), .MAX_OUTST(2)) u_b (
      .clk(clk), .reset(reset), .data_sram_req(req[1]), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .stall_inj(stall), .data_sram_addr_ok(addr_ok[1]),
      .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1]));

   data_sram_like_slave #(.IDX_W(10), .RD_LAT(4), .MAX_OUTST(4)) u_c (
      .clk(clk), .reset(reset), .data_sram_req(req[2]), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .stall_inj(stall), .data_sram_addr_ok(addr_ok[2]),
      .data_sram_data_ok(data_ok[2]), .data_sram_rdata(rdata[2]));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // present one request to dut d, hold it until accepted, report accept cycle
   task automatic issue(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp, output int t_acc);
      bit got;
      got = 0;
      t_acc = -1;
      @(negedge clk);
      wr = w; wstrb = s; addr = a; wdata = wd; size = 2'd2;
      req[d] = 1'b1;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (addr_ok[d]) begin got = 1; break; end
         @(negedge clk);
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL accept_timeout dut%0d addr=%h: got no addr_ok required accept", d, a);
         req[d] = 1'b0;
      end else begin
         t_acc = cyc;
         sb.push_back('{dut: d, data: exp, cyc: cyc + lat_of(d)});
         @(posedge clk);
         #1 req[d] = 1'b0;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   // pop the oldest expectation of the responding dut and compare data and cycle
   always @(negedge clk) begin
      int k;
      if (reset) begin
         for (int d = 0; d < 3; d++) begin
            if (data_ok[d]) begin
               k = -1;
               for (int i = 0; i < sb.size(); i++)
                  if (sb[i].dut == d) begin k = i; break; end
               tests++;
               if (k < 0) begin
                  fails++;
                  $display("FAIL unexpected_data_ok dut%0d: got rdata=%h required no response", d, rdata[d]);
               end else begin
                  if (rdata[d] !== sb[k].data || cyc != sb[k].cyc) begin
                     fails++;
                     $display("FAIL response dut%0d: got rdata=%h cyc=%0d required rdata=%h cyc=%0d",
                              d, rdata[d], cyc, sb[k].data, sb[k].cyc);
                  end
                  sb.delete(k);
               end
            end
         end
      end
   end

   logic [0:9] pat;
   int t, t0;

   initial begin
      reset = 1; req = '0; wr = 0; stall = 0; size = 2'd2; wstrb = '0; addr = '0; wdata = '0;
      #2 reset = 0;
      #1;
      chk("reset_addr_ok", addr_ok, 3'b000);
      chk("reset_data_ok", data_ok, 3'b000);
      chk("reset_rdata", rdata[0], 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1;
      #1 chk("post_reset_addr_ok", addr_ok, 3'b111);

      // word store then RAW load
      issue(0, 1, 4'hF, 32'h100, 32'h1234_5678, 32'h0, t);
      issue(0, 0, 4'h0, 32'h100, 32'h0, 32'h1234_5678, t);
      // byte lane 2 merge, and an empty-strobe store that changes nothing
      issue(0, 1, 4'h4, 32'h100, 32'h00AA_0000, 32'h0, t);
      issue(0, 0, 4'h0, 32'h100, 32'h0, 32'h12AA_5678, t);
      issue(0, 1, 4'h0, 32'h100, 32'hFFFF_FFFF, 32'h0, t);
      issue(0, 0, 4'h0, 32'h100, 32'h0, 32'h12AA_5678, t);
      // load keeps its captured word even when a store follows immediately
      issue(0, 0, 4'h0, 32'h100, 32'h0, 32'h12AA_5678, t);
      issue(0, 1, 4'hF, 32'h100, 32'h5555_5555, 32'h0, t);
      issue(0, 0, 4'h0, 32'h100, 32'h0, 32'h5555_5555, t);
      // aliasing of the upper address bits, low two bits ignored
      issue(0, 1, 4'hF, 32'h0, 32'hDEAD_BEEF, 32'h0, t);
      issue(0, 0, 4'h0, 32'h1000, 32'h0, 32'hDEAD_BEEF, t);
      issue(0, 0, 4'h0, 32'h1003, 32'h0, 32'hDEAD_BEEF, t);
      drain();

      // injected stall blocks acceptance
      @(negedge clk);
      stall = 1; wr = 0; addr = 32'h0; req[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_addr_ok", addr_ok[0], 1'b0);
         @(negedge clk);
      end
      req[0] = 1'b0; stall = 0;
      repeat (4) @(negedge clk);
      chk("stall_no_response", sb.size(), 0);

      // eight back-to-back loads with no gaps
      for (int i = 0; i < 8; i++)
         issue(0, 1, 4'hF, 32'h200 + 4*i, 32'hC0DE_0000 | i, 32'h0, t);
      drain();
      issue(0, 0, 4'h0, 32'h200, 32'h0, 32'hC0DE_0000, t0);
      for (int i = 1; i < 8; i++) begin
         issue(0, 0, 4'h0, 32'h200 + 4*i, 32'h0, 32'hC0DE_0000 | i, t);
         chk("b2b_accept_cycle", t, t0 + i);
      end
      drain();

      // RD_LAT=4, MAX_OUTST=2 with request held: slots free a cycle after retire
      issue(1, 1, 4'hF, 32'h40, 32'h0BAD_F00D, 32'h0, t);
      drain();
      pat = 10'b1100011000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         wr = 0; addr = 32'h40; req[1] = 1'b1;
         #1 chk("held_addr_ok", addr_ok[1], pat[i]);
         if (addr_ok[1]) sb.push_back('{dut: 1, data: 32'h0BAD_F00D, cyc: cyc + 4});
      end
      @(negedge clk) req[1] = 1'b0;
      drain();

      // reset with three in flight: they are dropped for good
      issue(2, 1, 4'hF, 32'h0, 32'h1, 32'h0, t);
      issue(2, 1, 4'hF, 32'h4, 32'h2, 32'h0, t);
      issue(2, 1, 4'hF, 32'h8, 32'h3, 32'h0, t);
      #1 reset = 0;
      #1;
      chk("midrun_reset_addr_ok", addr_ok, 3'b000);
      chk("midrun_reset_data_ok", data_ok, 3'b000);
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].dut == 2) sb.delete(i);
      repeat (2) @(negedge clk);
      reset = 1;
      repeat (12) @(negedge clk);
      chk("post_midrun_addr_ok", addr_ok[2], 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
